// File: rtl/init_reset_sequencer.sv
// -----------------------------------------------------------------------------
// init_reset_sequencer
//
// Releases the transceiver, peripheral and fabric reset domains in order once
// device init monitors report done and the PLL has been stably locked. Loss of
// lock, loss of DEVICE_INIT_DONE or an external soft reset pulls the sequence
// back to the appropriate earlier state.
//
// Parameters
//   HOLD_CYCLES  : stable-hold / stage-spacing count in CLK cycles (1..65535)
//   LOCK_TIMEOUT : WAIT_LOCK watchdog limit in CLK cycles (1..65535)
//
// Ports
//   CLK                 : fabric clock, all state changes on rising edge
//   RESETN              : asynchronous active-low reset
//   DEVICE_INIT_DONE,
//   SRAM_INIT_DONE,
//   USRAM_INIT_DONE,
//   XCVR_INIT_DONE      : asynchronous init-monitor status
//   PLL_LOCK            : asynchronous PLL lock indication
//   EXT_RST_N           : asynchronous active-low soft reset request
//   XCVR_RESET_N,
//   PERIPH_RESET_N,
//   FABRIC_RESET_N      : registered active-low domain resets
//   READY               : registered, high only in RUN
//   STATE[2:0]          : registered state encoding
//   TIMEOUT             : registered sticky lock-timeout flag
//
// Optional feature macro: INIT_SEQ_TIMEOUT_EN
//   Defined   -> WAIT_LOCK watchdog; expiry enters FAULT and sets TIMEOUT.
//   Undefined -> no watchdog logic, FAULT unreachable, TIMEOUT tied low.
// -----------------------------------------------------------------------------
module init_reset_sequencer #(
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       DEVICE_INIT_DONE,
  input  logic       SRAM_INIT_DONE,
  input  logic       USRAM_INIT_DONE,
  input  logic       XCVR_INIT_DONE,
  input  logic       PLL_LOCK,
  input  logic       EXT_RST_N,
  output logic       XCVR_RESET_N,
  output logic       PERIPH_RESET_N,
  output logic       FABRIC_RESET_N,
  output logic       READY,
  output logic [2:0] STATE,
  output logic       TIMEOUT
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535 ||
      LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 65535) begin : g_param_range_bad
    $error("init_reset_sequencer: HOLD_CYCLES/LOCK_TIMEOUT out of range 1..65535");
  end

  typedef enum logic [2:0] {
    WAIT_INIT  = 3'd0,
    WAIT_LOCK  = 3'd1,
    REL_XCVR   = 3'd2,
    REL_PERIPH = 3'd3,
    RUN        = 3'd4,
    FAULT      = 3'd5
  } state_e;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers, bit order {ext, lock, xcvr, usram, sram, device}
  // ---------------------------------------------------------------------------
  logic [5:0] async_in;
  logic [5:0] meta_q, meta_d;
  logic [5:0] sync_q, sync_d;

  assign async_in = {EXT_RST_N, PLL_LOCK, XCVR_INIT_DONE,
                     USRAM_INIT_DONE, SRAM_INIT_DONE, DEVICE_INIT_DONE};

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  logic dev_s, sram_s, usram_s, xcvr_s, lock_s, ext_s;
  assign {ext_s, lock_s, xcvr_s, usram_s, sram_s, dev_s} = sync_q;

  // ---------------------------------------------------------------------------
  // State register and stage counter
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;

`ifdef INIT_SEQ_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(LOCK_TIMEOUT - 1);
  logic [15:0] wd_q, wd_d;
  logic [15:0] wd_inc;
  assign wd_inc = (wd_q == '1) ? wd_q : wd_q + 16'd1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef INIT_SEQ_TIMEOUT_EN
    wd_d    = '0;
`endif

    case (state_q)
      WAIT_INIT: begin
        cnt_d = '0;
        if (dev_s && sram_s && usram_s) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = REL_XCVR;
        end else begin
          cnt_d = cnt_inc;
        end
`ifdef INIT_SEQ_TIMEOUT_EN
        // Watchdog counts every cycle spent here; a completed lock hold in
        // the same cycle as expiry still wins.
        wd_d = wd_inc;
        if (state_d == WAIT_LOCK && wd_q == WD_LAST) begin
          state_d = FAULT;
          cnt_d   = '0;
        end
`endif
      end
      REL_XCVR: begin
        if (xcvr_s) begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d   = '0;
            state_d = REL_PERIPH;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      REL_PERIPH: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RUN: begin
        cnt_d = '0;
      end
`ifdef INIT_SEQ_TIMEOUT_EN
      FAULT: begin
        cnt_d = '0;
      end
`endif
      default: begin
        cnt_d   = '0;
        state_d = WAIT_INIT;
      end
    endcase

    // Fault overrides, applied lowest priority first so the later ones win.
    if (!lock_s && (state_q inside {REL_XCVR, REL_PERIPH, RUN})) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end
    if (!dev_s && (state_q inside {WAIT_LOCK, REL_XCVR, REL_PERIPH, RUN})) begin
      state_d = WAIT_INIT;
      cnt_d   = '0;
    end
    if (!ext_s) begin
      state_d = WAIT_INIT;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= WAIT_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef INIT_SEQ_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) wd_q <= '0;
    else         wd_q <= wd_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // Registered output decodes (one cycle behind the state register)
  // ---------------------------------------------------------------------------
  logic       xcvr_rst_n_q, xcvr_rst_n_d;
  logic       periph_rst_n_q, periph_rst_n_d;
  logic       fabric_rst_n_q, fabric_rst_n_d;
  logic       ready_q, ready_d;
  logic [2:0] state_out_q, state_out_d;

  always_comb begin
    xcvr_rst_n_d   = state_q inside {REL_XCVR, REL_PERIPH, RUN};
    periph_rst_n_d = state_q inside {REL_PERIPH, RUN};
    fabric_rst_n_d = (state_q == RUN);
    ready_d        = (state_q == RUN);
    state_out_d    = state_q;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      xcvr_rst_n_q   <= 1'b0;
      periph_rst_n_q <= 1'b0;
      fabric_rst_n_q <= 1'b0;
      ready_q        <= 1'b0;
      state_out_q    <= '0;
    end else begin
      xcvr_rst_n_q   <= xcvr_rst_n_d;
      periph_rst_n_q <= periph_rst_n_d;
      fabric_rst_n_q <= fabric_rst_n_d;
      ready_q        <= ready_d;
      state_out_q    <= state_out_d;
    end
  end

  assign XCVR_RESET_N   = xcvr_rst_n_q;
  assign PERIPH_RESET_N = periph_rst_n_q;
  assign FABRIC_RESET_N = fabric_rst_n_q;
  assign READY          = ready_q;
  assign STATE          = state_out_q;

`ifdef INIT_SEQ_TIMEOUT_EN
  // Sticky: only RESETN clears it, an EXT_RST_N recovery from FAULT does not.
  logic timeout_q, timeout_d;
  always_comb timeout_d = timeout_q | (state_q == FAULT);
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) timeout_q <= 1'b0;
    else         timeout_q <= timeout_d;
  end
  assign TIMEOUT = timeout_q;
`else
  assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_init_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_init_reset_sequencer
//
// Directed scenarios (ordered release, lock glitch, lock loss in RUN, soft
// reset vs lock loss, async reset, watchdog) followed by randomized input
// activity, all compared every cycle against a behavioural model of the
// sequencer. Build with INIT_SEQ_TIMEOUT_EN defined to cover the watchdog.
// -----------------------------------------------------------------------------
module tb_init_reset_sequencer;

  localparam int H  = 4;
  localparam int LT = 32;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       DEVICE_INIT_DONE = 1'b1;
  logic       SRAM_INIT_DONE = 1'b1;
  logic       USRAM_INIT_DONE = 1'b1;
  logic       XCVR_INIT_DONE = 1'b1;
  logic       PLL_LOCK = 1'b1;
  logic       EXT_RST_N = 1'b1;
  logic       XCVR_RESET_N, PERIPH_RESET_N, FABRIC_RESET_N, READY, TIMEOUT;
  logic [2:0] STATE;

  always #5 CLK = ~CLK;

  init_reset_sequencer #(
    .HOLD_CYCLES (H),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .CLK             (CLK),
    .RESETN          (RESETN),
    .DEVICE_INIT_DONE(DEVICE_INIT_DONE),
    .SRAM_INIT_DONE  (SRAM_INIT_DONE),
    .USRAM_INIT_DONE (USRAM_INIT_DONE),
    .XCVR_INIT_DONE  (XCVR_INIT_DONE),
    .PLL_LOCK        (PLL_LOCK),
    .EXT_RST_N       (EXT_RST_N),
    .XCVR_RESET_N    (XCVR_RESET_N),
    .PERIPH_RESET_N  (PERIPH_RESET_N),
    .FABRIC_RESET_N  (FABRIC_RESET_N),
    .READY           (READY),
    .STATE           (STATE),
    .TIMEOUT         (TIMEOUT)
  );

  // Observed outputs packed as {TIMEOUT, READY, FABRIC, PERIPH, XCVR, STATE}
  logic [7:0] dut_vec;
  assign dut_vec = {TIMEOUT, READY, FABRIC_RESET_N, PERIPH_RESET_N, XCVR_RESET_N, STATE};

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. Inputs reach the decision logic two samples late; the
  // phase then advances by the sequencing rules, and visible outputs show the
  // phase one cycle later. Bit order of samples: {ext,lock,xcvr,usram,sram,dev}.
  // ---------------------------------------------------------------------------
  logic [5:0] m_late1, m_late2;   // sample one / two edges old
  int         m_phase;            // 0 init,1 lock,2 xcvr,3 periph,4 run,5 fault
  int         m_held;             // qualifying cycles accumulated in this phase
  int         m_lockwait;         // cycles spent in the lock phase so far
  bit         m_to;
  logic [7:0] m_out;

  task automatic model_reset();
    m_late1 = '0; m_late2 = '0;
    m_phase = 0; m_held = 0; m_lockwait = 0; m_to = 1'b0; m_out = '0;
  endtask

  task automatic model_edge(input logic [5:0] smp);
    bit ext, lock, xd, all_init, dev;
    int np, nh;
    ext = m_late2[5]; lock = m_late2[4]; xd = m_late2[3]; dev = m_late2[0];
    all_init = &m_late2[2:0];

    m_to  = m_to || (m_phase == 5);
    m_out = {m_to, m_phase == 4, m_phase == 4, m_phase >= 3 && m_phase <= 4,
             m_phase >= 2 && m_phase <= 4, 3'(m_phase)};

    np = m_phase; nh = m_held;
    if (!ext) begin
      np = 0; nh = 0;
    end else if (!dev && m_phase >= 1 && m_phase <= 4) begin
      np = 0; nh = 0;
    end else if (!lock && m_phase >= 2 && m_phase <= 4) begin
      np = 1; nh = 0;
    end else begin
      case (m_phase)
        0: begin nh = 0; if (all_init) np = 1; end
        1: begin
          if (!lock) nh = 0;
          else if (m_held + 1 == H) begin np = 2; nh = 0; end
          else nh = m_held + 1;
`ifdef INIT_SEQ_TIMEOUT_EN
          if (np == 1 && m_lockwait + 1 == LT) begin np = 5; nh = 0; end
`endif
        end
        2: if (xd) begin
          if (m_held + 1 == H) begin np = 3; nh = 0; end
          else nh = m_held + 1;
        end
        3: if (m_held + 1 == H) begin np = 4; nh = 0; end
           else nh = m_held + 1;
        default: nh = 0;
      endcase
    end
    m_lockwait = (m_phase == 1 && np == 1) ? m_lockwait + 1 : 0;
    m_phase = np; m_held = nh;
    m_late2 = m_late1; m_late1 = smp;
  endtask

  task automatic tick();
    logic [5:0] cur;
    cur = {EXT_RST_N, PLL_LOCK, XCVR_INIT_DONE, USRAM_INIT_DONE, SRAM_INIT_DONE, DEVICE_INIT_DONE};
    @(posedge CLK);
    #1;
    if (RESETN) model_edge(cur);
    cyc = cyc + 1;
    check("model_cycle", 32'(dut_vec), 32'(m_out));
  endtask

  task automatic do_reset();
    RESETN = 1'b0;
    #1;
    model_reset();
    check("reset_async", 32'(dut_vec), 32'h0);
    @(posedge CLK);
    #1;
    check("reset_held", 32'(dut_vec), 32'h0);
    RESETN = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int xr, pr, fr, rr;
    logic [5:0] v;
    model_reset();

    // Ordered release with everything ready from reset release.
    do_reset();
    xr = -1; pr = -1; fr = -1; rr = -1;
    repeat (20) begin
      tick();
      if (xr < 0 && XCVR_RESET_N)   xr = cyc;
      if (pr < 0 && PERIPH_RESET_N) pr = cyc;
      if (fr < 0 && FABRIC_RESET_N) fr = cyc;
      if (rr < 0 && READY)          rr = cyc;
    end
    check("xcvr_rise_cycle", 32'(xr), 32'd8);
    check("periph_gap", 32'(pr - xr), 32'(H));
    check("fabric_gap", 32'(fr - pr), 32'(H));
    check("ready_with_fabric", 32'(rr), 32'(fr));
    check("run_reached", 32'(dut_vec), 32'h7C);

    // Lock loss in RUN: visible after exactly 4 edges, then full replay.
    PLL_LOCK = 1'b0;
    repeat (3) tick();
    check("lockloss_not_early", 32'(dut_vec), 32'h7C);
    tick();
    check("lockloss_wait_lock", 32'(dut_vec), 32'h01);
    PLL_LOCK = 1'b1;
    repeat (20) tick();
    check("lockloss_replay_run", 32'(dut_vec), 32'h7C);

    // Soft reset and lock loss together: soft reset wins.
    PLL_LOCK = 1'b0; EXT_RST_N = 1'b0;
    repeat (4) tick();
    check("ext_over_lock", 32'(dut_vec), 32'h00);
    PLL_LOCK = 1'b1; EXT_RST_N = 1'b1;
    repeat (22) tick();
    check("ext_replay_run", 32'(dut_vec), 32'h7C);

    // One-cycle lock glitch while the hold count is at 2.
    do_reset();
    repeat (3) tick();
    PLL_LOCK = 1'b0;
    tick();
    PLL_LOCK = 1'b1;
    repeat (6) tick();
    check("glitch_xcvr_held", 32'(XCVR_RESET_N), 32'd0);
    tick();
    check("glitch_xcvr_rise", 32'(XCVR_RESET_N), 32'd1);

    // Asynchronous reset in REL_PERIPH.
    repeat (5) tick();
    check("in_rel_periph", 32'(dut_vec), 32'h1B);
    #2;
    RESETN = 1'b0;
    #1;
    check("async_reset_mid_cycle", 32'(dut_vec), 32'h00);
    model_reset();

`ifdef INIT_SEQ_TIMEOUT_EN
    // Watchdog expiry with lock held low, then soft-reset recovery.
    PLL_LOCK = 1'b0;
    do_reset();
    repeat (35) tick();
    check("wd_not_early", 32'(dut_vec), 32'h01);
    tick();
    check("wd_fault", 32'(dut_vec), 32'h85);
    EXT_RST_N = 1'b0;
    tick();
    EXT_RST_N = 1'b1;
    repeat (3) tick();
    check("fault_cleared_sticky", 32'(dut_vec), 32'h80);
    repeat (10) tick();
    PLL_LOCK = 1'b1;
`else
    // Without the watchdog, a missing lock just waits.
    PLL_LOCK = 1'b0;
    do_reset();
    repeat (100) tick();
    check("no_wd_waits", 32'(dut_vec), 32'h01);
    PLL_LOCK = 1'b1;
`endif

    // Randomized input activity, mostly-high inputs with occasional drops.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tick();
      v = {EXT_RST_N, PLL_LOCK, XCVR_INIT_DONE, USRAM_INIT_DONE, SRAM_INIT_DONE, DEVICE_INIT_DONE};
      for (int b = 0; b < 6; b++) begin
        if (v[b]) begin
          if ($urandom_range(0, (b == 5) ? 199 : 59) == 0) v[b] = 1'b0;
        end else begin
          if ($urandom_range(0, 2) == 0) v[b] = 1'b1;
        end
      end
      {EXT_RST_N, PLL_LOCK, XCVR_INIT_DONE, USRAM_INIT_DONE, SRAM_INIT_DONE, DEVICE_INIT_DONE} = v;
      if ($urandom_range(0, 799) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
